// File: rtl/spi_peripheral_if.sv
// Host-side handshake bundle for spi_peripheral.
// Carries overrun/ovr_clr when SPI_PERIPHERAL_OVERRUN_EN is defined.
interface spi_peripheral_if;
  logic [7:0] txdata;
  logic       txload;
  logic       txfull;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       rxack;
  logic       busy;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic       overrun;
  logic       ovr_clr;

  modport master (
    output txdata, txload, rxack, ovr_clr,
    input  txfull, rxdata, rxvalid, busy, overrun
  );
  modport slave (
    input  txdata, txload, rxack, ovr_clr,
    output txfull, rxdata, rxvalid, busy, overrun
  );
`else
  modport master (
    output txdata, txload, rxack,
    input  txfull, rxdata, rxvalid, busy
  );
  modport slave (
    input  txdata, txload, rxack,
    output txfull, rxdata, rxvalid, busy
  );
`endif
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target, 8-bit MSB first, fully oversampled in clk.
// Define SPI_PERIPHERAL_OVERRUN_EN for a sticky receive-overrun flag.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_mosi,
  input  logic spi_ssel_n,
  output logic spi_miso,
  spi_peripheral_if.slave host
);

  typedef enum logic {
    IDLE,
    SEL
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] ssel_q;
  logic sck_s, mosi_s, ssel_s;
  logic sck_d, ssel_d;
  logic sck_rise, sck_fall;
  logic ssel_asrt, ssel_dsrt;

  logic [2:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] tx_buf;
  logic [7:0] tx_next;
  logic [7:0] rx_byte;
  logic [7:0] rxdata;
  logic       txfull;
  logic       rxvalid;
  logic       rx_done;
  logic       load_pend;
  logic       tx_take;
  logic       miso;

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign ssel_s = ssel_q[SYNC_STAGES-1];

  assign sck_rise  =  sck_s & ~sck_d;
  assign sck_fall  = ~sck_s &  sck_d;
  assign ssel_asrt = ~ssel_s &  ssel_d;
  assign ssel_dsrt =  ssel_s & ~ssel_d;

  assign tx_next = txfull ? tx_buf : IDLE_TX;
  assign rx_byte = {rx_sh[6:0], mosi_s};

  // Shifter reloads at select and on the fall that follows each byte.
  assign tx_take = (state == IDLE && ssel_asrt) ||
                   (state == SEL && !ssel_dsrt &&
                    sck_fall && load_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q     <= '0;
      mosi_q    <= '1;
      ssel_q    <= '1;
      sck_d     <= 1'b0;
      ssel_d    <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      tx_buf    <= 8'h00;
      txfull    <= 1'b0;
      rxdata    <= 8'h00;
      rxvalid   <= 1'b0;
      rx_done   <= 1'b0;
      load_pend <= 1'b0;
      miso      <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      ssel_q <= {ssel_q[SYNC_STAGES-2:0], spi_ssel_n};
      sck_d  <= sck_s;
      ssel_d <= ssel_s;

      rx_done <= 1'b0;

      if (host.txload) begin
        tx_buf <= host.txdata;
        txfull <= 1'b1;
      end else if (tx_take) begin
        txfull <= 1'b0;
      end

      if (rx_done) begin
        rxvalid <= 1'b1;
      end else if (host.rxack) begin
        rxvalid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          miso      <= 1'b1;
          bit_cnt   <= 3'd0;
          load_pend <= 1'b0;
          if (ssel_asrt) begin
            state <= SEL;
            tx_sh <= tx_next;
            miso  <= tx_next[7];
          end
        end
        SEL: begin
          if (ssel_dsrt) begin
            state     <= IDLE;
            miso      <= 1'b1;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            load_pend <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rxdata    <= rx_byte;
                rx_done   <= 1'b1;
                load_pend <= 1'b1;
              end
            end
            if (sck_fall) begin
              if (load_pend) begin
                tx_sh     <= tx_next;
                miso      <= tx_next[7];
                load_pend <= 1'b0;
              end else begin
                tx_sh <= {tx_sh[6:0], 1'b0};
                miso  <= tx_sh[6];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (rx_done && rxvalid && !host.rxack) begin
      ovr <= 1'b1;
    end else if (host.ovr_clr) begin
      ovr <= 1'b0;
    end
  end

  assign host.overrun = ovr;
`endif

  assign spi_miso     = miso;
  assign host.txfull  = txfull;
  assign host.rxdata  = rxdata;
  assign host.rxvalid = rxvalid;
  assign host.busy    = ~ssel_s;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboarded random/directed bench for spi_peripheral.
module tb_spi_peripheral;

  localparam int         S    = 2;
  localparam int         HALF = 6;
  localparam logic [7:0] IDLE = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  logic spi_sck;
  logic spi_mosi;
  logic spi_ssel_n;
  logic spi_miso;

  spi_peripheral_if bus ();

  spi_peripheral #(
    .SYNC_STAGES(S),
    .IDLE_TX    (IDLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_ssel_n(spi_ssel_n),
    .spi_miso  (spi_miso),
    .host      (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit auto_ack = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] pend;
  bit         pend_v;

  logic [7:0] f_mo[4];
  bit         f_ld[4];
  logic [7:0] f_ldv[4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit model: newest loaded byte wins, else the idle byte.
  function automatic void model_load(input logic [7:0] v);
    pend   = v;
    pend_v = 1'b1;
  endfunction

  function automatic logic [7:0] model_take();
    logic [7:0] r;
    r      = pend_v ? pend : IDLE;
    pend_v = 1'b0;
    return r;
  endfunction

  // Receive monitor: pops the scoreboard whenever a byte is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && !rst) begin
        if (bus.rxvalid && !bus.rxack) begin
          if (exp_rx.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL rx_unexpected: got %0h expected no byte",
                     bus.rxdata);
          end else begin
            check("rxdata", bus.rxdata, exp_rx.pop_front());
          end
          bus.rxack = 1'b1;
        end else begin
          bus.rxack = 1'b0;
        end
      end
    end
  end

  task automatic txload_pulse(input logic [7:0] v);
    bus.txdata = v;
    bus.txload = 1'b1;
    @(negedge clk);
    bus.txload = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits,
                      input bit do_ld, input logic [7:0] ldv,
                      input bit ack_done, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      mi[7-i] = spi_miso;
      spi_sck = 1'b1;
      if (do_ld && i == 2) begin
        txload_pulse(ldv);
        repeat (HALF-2) @(negedge clk);
      end else if (ack_done && i == 7) begin
        repeat (S) @(negedge clk);
        bus.rxack = 1'b1;
        repeat (2) @(negedge clk);
        bus.rxack = 1'b0;
        repeat (HALF-S-2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic sel_on(input bit chk_busy);
    int k = 0;
    spi_ssel_n = 1'b0;
    while (k < S+1 && !bus.busy) begin
      @(negedge clk);
      k++;
    end
    if (chk_busy) check("busy_assert", bus.busy, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic sel_off();
    repeat (HALF) @(negedge clk);
    spi_ssel_n = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_deassert", bus.busy, 0);
  endtask

  task automatic run_frame(input int nb, input bit push_rx,
                           input bit ack_last, input bit chk_busy);
    logic [7:0] expv;
    logic [7:0] mi;
    expv = model_take();
    sel_on(chk_busy);
    check("miso_first", spi_miso, expv[7]);
    check("txfull_sel", bus.txfull, pend_v);
    for (int b = 0; b < nb; b++) begin
      if (push_rx) exp_rx.push_back(f_mo[b]);
      xfer(f_mo[b], 8, f_ld[b], f_ldv[b],
           ack_last && (b == nb-1), mi);
      check("miso_byte", mi, expv);
      if (f_ld[b]) model_load(f_ldv[b]);
      expv = model_take();
    end
    sel_off();
  endtask

  task automatic manual_ack();
    bus.rxack = 1'b1;
    @(negedge clk);
    bus.rxack = 1'b0;
    @(negedge clk);
    check("rxvalid_ack", bus.rxvalid, 0);
  endtask

  initial begin
    logic [7:0] expv;
    logic [7:0] mi;
    int         k;

    rst        = 1'b1;
    spi_sck    = 1'b0;
    spi_mosi   = 1'b1;
    spi_ssel_n = 1'b1;
    bus.txdata = 8'h00;
    bus.txload = 1'b0;
    bus.rxack  = 1'b0;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    bus.ovr_clr = 1'b0;
`endif
    pend   = 8'h00;
    pend_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_mo[i]  = 8'h00;
      f_ld[i]  = 1'b0;
      f_ldv[i] = 8'h00;
    end

    repeat (4) @(negedge clk);
    check("rst_miso", spi_miso, 1);
    check("rst_txfull", bus.txfull, 0);
    check("rst_rxdata", bus.rxdata, 0);
    check("rst_rxvalid", bus.rxvalid, 0);
    check("rst_busy", bus.busy, 0);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    check("rst_overrun", bus.overrun, 0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);
    auto_ack = 1'b1;

    // Select with nothing loaded: idle byte goes out.
    f_mo[0] = 8'($urandom);
    f_ld[0] = 1'b0;
    run_frame(1, 1'b1, 1'b0, 1'b1);

    // Single preloaded byte.
    txload_pulse(8'hA5);
    model_load(8'hA5);
    check("txfull_load", bus.txfull, 1);
    f_mo[0] = 8'h3C;
    run_frame(1, 1'b1, 1'b0, 1'b0);

    // Back-to-back bytes, second loaded mid-byte.
    txload_pulse(8'h12);
    model_load(8'h12);
    f_mo[0]  = 8'($urandom);
    f_ld[0]  = 1'b1;
    f_ldv[0] = 8'h34;
    f_mo[1]  = 8'($urandom);
    f_ld[1]  = 1'b0;
    run_frame(2, 1'b1, 1'b0, 1'b0);

    // Abort after 5 bits with a byte loaded mid-frame.
    expv = model_take();
    sel_on(1'b0);
    xfer(8'hF0, 5, 1'b1, 8'h5A, 1'b0, mi);
    model_load(8'h5A);
    check("abort_miso", mi[7:3], expv[7:3]);
    sel_off();
    check("abort_rxvalid", bus.rxvalid, 0);
    check("abort_txfull", bus.txfull, 1);
    f_mo[0] = 8'h81;
    f_ld[0] = 1'b0;
    run_frame(1, 1'b1, 1'b0, 1'b0);

    k = 0;
    while (k < 50 && (exp_rx.size() != 0 || bus.rxvalid)) begin
      @(negedge clk);
      k++;
    end
    auto_ack = 1'b0;
    @(negedge clk);
    bus.rxack = 1'b0;

    // rxack coinciding with the second byte's completion.
    f_mo[0] = 8'($urandom);
    f_ld[0] = 1'b0;
    f_mo[1] = 8'($urandom);
    f_ld[1] = 1'b0;
    run_frame(2, 1'b0, 1'b1, 1'b0);
    check("ackcoin_rxvalid", bus.rxvalid, 1);
    check("ackcoin_rxdata", bus.rxdata, f_mo[1]);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    check("ackcoin_overrun", bus.overrun, 0);
`endif
    manual_ack();

    // Two unread bytes: second overwrites the first.
    f_mo[0] = 8'($urandom);
    f_mo[1] = 8'($urandom);
    run_frame(2, 1'b0, 1'b0, 1'b0);
    check("ovw_rxvalid", bus.rxvalid, 1);
    check("ovw_rxdata", bus.rxdata, f_mo[1]);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    check("overrun_set", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    @(negedge clk);
    check("overrun_clr", bus.overrun, 0);
`endif
    manual_ack();
    auto_ack = 1'b1;

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int nb;
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] v;
        v = 8'($urandom);
        txload_pulse(v);
        model_load(v);
      end
      nb = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) begin
        f_mo[b]  = 8'($urandom);
        f_ld[b]  = 1'($urandom_range(0, 1));
        f_ldv[b] = 8'($urandom);
      end
      run_frame(nb, 1'b1, 1'b0, 1'b0);
    end

    k = 0;
    while (k < 200 && (exp_rx.size() != 0 || bus.rxvalid)) begin
      @(negedge clk);
      k++;
    end
    check("rx_drain", exp_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
